// File: rtl/mapper_mem_resp_pkg.sv
// Shared types and constants for the slot mapper memory responder.
// Access classification is decided once, at request capture.
package mapper_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SRAM_RD,
    SDRAM_WAIT,
    DONE
  } resp_state_t;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_SRAM_WR,
    ACC_SRAM_RD,
    ACC_HIT,
    ACC_SDRAM
  } acc_kind_t;

  localparam logic [7:0] DATA_NONE = 8'hFF;

  // SRAM select wins over SDRAM; only SDRAM reads can be served from the cache.
  function automatic acc_kind_t classify(input logic rnw, input logic ram_cs,
                                         input logic sram_cs, input logic hit);
    acc_kind_t kind;
    kind = ACC_NONE;
    if (sram_cs) begin
      kind = rnw ? ACC_SRAM_RD : ACC_SRAM_WR;
    end else if (ram_cs) begin
      kind = (rnw && hit) ? ACC_HIT : ACC_SDRAM;
    end
    return kind;
  endfunction

endpackage

// File: rtl/mapper_mem_responder_if.sv
// CPU-side memory bus between the slot mapper aggregation and the responder.
// master = mapper/CPU side, slave = memory responder.
interface mapper_mem_responder_if #(
  parameter int ADDR_W = 27
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              rnw;
  logic              ram_cs;
  logic              sram_cs;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              done;
  logic              wait_n;

  modport master (
    output req, addr, rnw, ram_cs, sram_cs, din,
    input  dout, done, wait_n
  );

  modport slave (
    input  req, addr, rnw, ram_cs, sram_cs, din,
    output dout, done, wait_n
  );

endinterface

// File: rtl/mapper_mem_resp_cache.sv
// Single-entry read cache in front of the SDRAM port.
// Tags are full bus addresses, shared by SRAM and SDRAM writes for invalidation.
module mapper_mem_resp_cache #(
  parameter int ADDR_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [7:0]        hit_data,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [7:0]        fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr
);

  logic [ADDR_W-1:0] tag_reg;
  logic [7:0]        data_reg;
  logic              valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (fill) begin
      tag_reg   <= fill_addr;
      data_reg  <= fill_data;
      valid_reg <= 1'b1;
    end else if (inval && (tag_reg == inval_addr)) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit      = valid_reg && (tag_reg == lookup_addr);
  assign hit_data = data_reg;

endmodule

// File: rtl/mapper_mem_responder.sv
// Memory-side responder: services mapper requests from SDRAM, on-chip SRAM
// or a one-entry read cache, and returns data with a done/wait handshake.
module mapper_mem_responder
  import mapper_mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int SRAM_AW = 18,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  mapper_mem_responder_if.slave bus,
  output logic               err_timeout,
  output logic               err_overrun,
  output logic               sdram_req,
  output logic [ADDR_W-1:0]  sdram_addr,
  output logic               sdram_we,
  output logic [7:0]         sdram_din,
  input  logic               sdram_ack,
  input  logic [7:0]         sdram_dout,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we,
  output logic [7:0]         sram_din,
  input  logic [7:0]         sram_dout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  resp_state_t       state_reg, state_next;
  acc_kind_t         kind_reg, kind_in;

  logic [ADDR_W-1:0] req_addr_reg;
  logic              req_rnw_reg;
  logic [7:0]        req_din_reg;
  logic [7:0]        cnt_reg;

  logic [7:0]        dout_reg;
  logic              done_reg;
  logic              sram_we_reg;
  logic              sdram_req_reg;
  logic [ADDR_W-1:0] sdram_addr_reg;
  logic              sdram_we_reg;
  logic [7:0]        sdram_din_reg;
  logic              err_timeout_reg;
  logic              err_overrun_reg;

  logic              accept;
  logic              sdram_take;
  logic              sdram_abort;
  logic [ADDR_W-1:0] lookup_addr;
  logic              cache_hit;
  logic [7:0]        cache_data;

  assign accept      = (state_reg == IDLE) && bus.req;
  assign sdram_take  = (state_reg == SDRAM_WAIT) && sdram_ack;
  // An ack arriving on the limit cycle still completes the access normally.
  assign sdram_abort = (state_reg == SDRAM_WAIT) && !sdram_ack && (cnt_reg == TIMEOUT_CNT);

  // Look up the incoming address while idle, the latched one while serving a hit.
  assign lookup_addr = (state_reg == IDLE) ? bus.addr : req_addr_reg;
  assign kind_in     = classify(bus.rnw, bus.ram_cs, bus.sram_cs, cache_hit);

  mapper_mem_resp_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .clk        (clk),
    .reset      (reset),
    .lookup_addr(lookup_addr),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .fill       (sdram_take && req_rnw_reg),
    .fill_addr  (req_addr_reg),
    .fill_data  (sdram_dout),
    .inval      (accept && !bus.rnw && (bus.ram_cs || bus.sram_cs)),
    .inval_addr (bus.addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // SDRAM completion returns straight to IDLE so done lands on ack + 1.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          case (kind_in)
            ACC_SRAM_RD: state_next = SRAM_RD;
            ACC_SDRAM:   state_next = SDRAM_WAIT;
            default:     state_next = DONE;
          endcase
        end
      end
      SRAM_RD:    state_next = DONE;
      SDRAM_WAIT: if (sdram_take || sdram_abort) state_next = IDLE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_reg        <= ACC_NONE;
      req_addr_reg    <= '0;
      req_rnw_reg     <= 1'b1;
      req_din_reg     <= '0;
      cnt_reg         <= '0;
      dout_reg        <= DATA_NONE;
      done_reg        <= 1'b0;
      sram_we_reg     <= 1'b0;
      sdram_req_reg   <= 1'b0;
      sdram_addr_reg  <= '0;
      sdram_we_reg    <= 1'b0;
      sdram_din_reg   <= '0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      done_reg    <= (state_reg == DONE) || sdram_take || sdram_abort;
      sram_we_reg <= accept && (kind_in == ACC_SRAM_WR);

      if (bus.req && (state_reg != IDLE)) err_overrun_reg <= 1'b1;
      if (sdram_abort)                    err_timeout_reg <= 1'b1;

      if (accept) begin
        kind_reg     <= kind_in;
        req_addr_reg <= bus.addr;
        req_rnw_reg  <= bus.rnw;
        req_din_reg  <= bus.din;
        cnt_reg      <= '0;
      end else if (state_reg == SDRAM_WAIT) begin
        cnt_reg <= cnt_reg + 8'd1;
      end

      if (accept && (kind_in == ACC_SDRAM)) begin
        sdram_req_reg  <= 1'b1;
        sdram_addr_reg <= bus.addr;
        sdram_we_reg   <= ~bus.rnw;
        sdram_din_reg  <= bus.din;
      end else if (sdram_take || sdram_abort) begin
        sdram_req_reg <= 1'b0;
      end

      // Writes leave dout alone; it only moves on read completion or abort.
      if (state_reg == DONE) begin
        case (kind_reg)
          ACC_NONE:    dout_reg <= DATA_NONE;
          ACC_SRAM_RD: dout_reg <= sram_dout;
          ACC_HIT:     dout_reg <= cache_data;
          default:     ;
        endcase
      end else if (sdram_take && req_rnw_reg) begin
        dout_reg <= sdram_dout;
      end else if (sdram_abort) begin
        dout_reg <= DATA_NONE;
      end
    end
  end

  assign bus.dout    = dout_reg;
  assign bus.done    = done_reg;
  assign bus.wait_n  = ~(bus.req | (state_reg != IDLE));

  assign err_timeout = err_timeout_reg;
  assign err_overrun = err_overrun_reg;
  assign sdram_req   = sdram_req_reg;
  assign sdram_addr  = sdram_addr_reg;
  assign sdram_we    = sdram_we_reg;
  assign sdram_din   = sdram_din_reg;
  assign sram_addr   = req_addr_reg[SRAM_AW-1:0];
  assign sram_we     = sram_we_reg;
  assign sram_din    = req_din_reg;

endmodule

// File: tb/tb_mapper_mem_responder.sv
// Bench for mapper_mem_responder: directed and random accesses checked against a
// transaction-level model of latency, data, cache and error flags.
module tb_mapper_mem_responder;
  import mapper_mem_resp_pkg::*;

  localparam int ADDR_W  = 27;
  localparam int SRAM_AW = 18;
  localparam int TIMEOUT = 16;
  localparam int MAX_CYC = 400;

  logic               clk = 1'b0;
  logic               reset;
  logic               err_timeout, err_overrun;
  logic               sdram_req, sdram_we, sdram_ack;
  logic [ADDR_W-1:0]  sdram_addr;
  logic [7:0]         sdram_din, sdram_dout;
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we;
  logic [7:0]         sram_din, sram_dout;

  mapper_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  mapper_mem_responder #(
    .ADDR_W (ADDR_W),
    .SRAM_AW(SRAM_AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_we   (sdram_we),
    .sdram_din  (sdram_din),
    .sdram_ack  (sdram_ack),
    .sdram_dout (sdram_dout),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;

  // Memories seen by the DUT (controller side) and the reference copies.
  logic [7:0] ctl_sdram [int];
  logic [7:0] ctl_sram  [int];
  logic [7:0] ref_sdram [int];
  logic [7:0] ref_sram  [int];

  // Reference model state.
  bit                m_valid = 0;
  logic [ADDR_W-1:0] m_tag = '0;
  logic [7:0]        m_dout = 8'hFF;
  bit                m_err_to = 0;
  bit                m_ovr = 0;

  function automatic logic [7:0] init_byte(input int k);
    return 8'(k) ^ 8'(k >>> 8) ^ 8'h5C;
  endfunction
  function automatic logic [7:0] ctl_sdram_rd(input int k);
    return ctl_sdram.exists(k) ? ctl_sdram[k] : init_byte(k);
  endfunction
  function automatic logic [7:0] ctl_sram_rd(input int k);
    return ctl_sram.exists(k) ? ctl_sram[k] : init_byte(k + 7);
  endfunction
  function automatic logic [7:0] ref_sdram_rd(input int k);
    return ref_sdram.exists(k) ? ref_sdram[k] : init_byte(k);
  endfunction
  function automatic logic [7:0] ref_sram_rd(input int k);
    return ref_sram.exists(k) ? ref_sram[k] : init_byte(k + 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SDRAM controller: acks ack_delay cycles after sdram_req first seen high.
  initial begin
    int wcnt;
    int k;
    wcnt = 0;
    sdram_ack = 1'b0;
    sdram_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      if (sdram_req === 1'b1) begin
        if (wcnt == ack_delay) begin
          sdram_ack = 1'b1;
          k = int'(sdram_addr);
          if (sdram_we) ctl_sdram[k] = sdram_din;
          else          sdram_dout = ctl_sdram_rd(k);
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // SRAM block RAM: one-cycle registered read.
  initial begin
    int a;
    logic we;
    logic [7:0] d;
    sram_dout = 8'h00;
    forever begin
      @(negedge clk);
      a = int'(sram_addr);
      we = sram_we;
      d = sram_din;
      @(posedge clk);
      #1;
      sram_dout = ctl_sram_rd(a);
      if (we === 1'b1) ctl_sram[a] = d;
    end
  end

  task automatic access(input logic [ADDR_W-1:0] a, input logic r, input logic rc,
                        input logic sc, input logic [7:0] d, input int dly,
                        input int pulse_at, input string tag);
    int exp_lat, exp_we, ka, ks, cyc, we_cnt;
    logic [7:0] exp_dout;
    bit exp_sdr, got, saw_sdr, wait_ok, addr_ok;
    ka = int'(a);
    ks = int'(a[SRAM_AW-1:0]);
    exp_dout = m_dout;
    exp_sdr = 0;
    exp_we = 0;
    exp_lat = 2;
    if (sc) begin
      if (r) begin
        exp_lat = 3;
        exp_dout = ref_sram_rd(ks);
      end else begin
        exp_we = 1;
        ref_sram[ks] = d;
        if (m_valid && m_tag == a) m_valid = 0;
      end
    end else if (rc) begin
      if (r && m_valid && m_tag == a) begin
        exp_dout = ref_sdram_rd(ka);
      end else begin
        exp_sdr = 1;
        if (!r && m_valid && m_tag == a) m_valid = 0;
        if (dly <= TIMEOUT) begin
          exp_lat = 2 + dly;
          if (r) begin
            exp_dout = ref_sdram_rd(ka);
            m_valid = 1;
            m_tag = a;
          end else begin
            ref_sdram[ka] = d;
          end
        end else begin
          exp_lat = TIMEOUT + 2;
          exp_dout = 8'hFF;
          m_err_to = 1;
        end
      end
    end else begin
      exp_dout = 8'hFF;
    end
    if (pulse_at > 0 && pulse_at < exp_lat) m_ovr = 1;
    m_dout = exp_dout;

    ack_delay = dly;
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.addr = a;
    bus.rnw = r;
    bus.ram_cs = rc;
    bus.sram_cs = sc;
    bus.din = d;
    @(negedge clk);
    chk({tag, ":wait_n_on_req"}, 32'(bus.wait_n), 32'd0);
    chk({tag, ":done_idle"}, 32'(bus.done), 32'd0);

    cyc = 0; got = 0; saw_sdr = 0; we_cnt = 0; wait_ok = 1; addr_ok = 1;
    while (!got && cyc < MAX_CYC) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.req = (cyc == pulse_at);
      bus.addr = (cyc == pulse_at) ? (a ^ 1) : a;
      @(negedge clk);
      if (sdram_req === 1'b1) begin
        saw_sdr = 1;
        if (sdram_addr !== a || sdram_we !== !r || (!r && sdram_din !== d)) addr_ok = 0;
      end
      if (sram_we === 1'b1) we_cnt++;
      if (bus.done === 1'b1) got = 1;
      else if (bus.wait_n !== 1'b0) wait_ok = 0;
    end
    bus.req = 1'b0;

    chk({tag, ":latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, ":dout"}, 32'(bus.dout), 32'(exp_dout));
    chk({tag, ":sdram_req_seen"}, 32'(saw_sdr), 32'(exp_sdr));
    chk({tag, ":sram_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    chk({tag, ":wait_n_low_while_busy"}, 32'(wait_ok), 32'd1);
    chk({tag, ":sdram_cmd_stable"}, 32'(addr_ok), 32'd1);
    chk({tag, ":err_timeout"}, 32'(err_timeout), 32'(m_err_to));
    chk({tag, ":err_overrun"}, 32'(err_overrun), 32'(m_ovr));
    $display("txn %-10s addr=%07h rnw=%0d ram=%0d sram=%0d din=%02h lat=%0d dout=%02h",
             tag, a, r, rc, sc, d, cyc, bus.dout);
  endtask

  initial begin
    logic [ADDR_W-1:0] pool [4];
    reset = 1'b1;
    bus.req = 1'b0;
    bus.addr = '0;
    bus.rnw = 1'b1;
    bus.ram_cs = 1'b0;
    bus.sram_cs = 1'b0;
    bus.din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset:dout", 32'(bus.dout), 32'hFF);
    chk("reset:wait_n", 32'(bus.wait_n), 32'd1);
    chk("reset:done", 32'(bus.done), 32'd0);
    chk("reset:sdram_req", 32'(sdram_req), 32'd0);
    chk("reset:sdram_we", 32'(sdram_we), 32'd0);
    chk("reset:sram_we", 32'(sram_we), 32'd0);
    chk("reset:errors", {30'd0, err_timeout, err_overrun}, 32'd0);

    access(27'h0001234, 1, 1, 0, 8'h00, 5, 0, "sd_rd");
    access(27'h0001234, 1, 1, 0, 8'h00, 5, 0, "sd_hit");
    access(27'h0000100, 0, 0, 1, 8'h3C, 0, 0, "sr_wr");
    access(27'h0000100, 1, 0, 1, 8'h00, 0, 0, "sr_rd");
    access(27'h0001234, 0, 1, 0, 8'h77, 2, 0, "sd_wr");
    access(27'h0001234, 1, 1, 0, 8'h00, 3, 0, "sd_rd_miss");
    access(27'h0001234, 1, 0, 0, 8'h00, 0, 0, "no_cs");
    access(27'h0000100, 1, 1, 1, 8'h00, 4, 0, "both_cs");
    access(27'h0004000, 1, 1, 0, 8'h00, TIMEOUT, 0, "ack_at_lim");
    access(27'h0005000, 1, 1, 0, 8'h00, TIMEOUT + 1, 0, "timeout");
    access(27'h0006000, 1, 1, 0, 8'h00, 4, 2, "overrun");

    pool[0] = 27'h0001234;
    pool[1] = 27'h0004000;
    pool[2] = 27'h7FFFFFF;
    pool[3] = 27'h0000100;
    for (int i = 0; i < 40; i++) begin
      int sel, dly;
      logic [ADDR_W-1:0] a;
      sel = int'($urandom_range(0, 3));
      a = pool[$urandom_range(0, 3)];
      dly = ($urandom_range(0, 15) == 0) ? TIMEOUT + 3 : int'($urandom_range(0, 6));
      access(a, 1'($urandom_range(0, 1)), (sel == 1 || sel == 3), (sel >= 2),
             8'($urandom), dly, 0, "random");
    end

    // Reset while an SDRAM access is pending with no ack coming.
    ack_delay = 1000;
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.addr = 27'h0004000;
    bus.rnw = 1'b1;
    bus.ram_cs = 1'b1;
    bus.sram_cs = 1'b0;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst:sdram_req", 32'(sdram_req), 32'd0);
    chk("midrst:dout", 32'(bus.dout), 32'hFF);
    chk("midrst:done", 32'(bus.done), 32'd0);
    chk("midrst:wait_n", 32'(bus.wait_n), 32'd1);
    chk("midrst:err_timeout", 32'(err_timeout), 32'd0);
    chk("midrst:err_overrun", 32'(err_overrun), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_valid = 0;
    m_dout = 8'hFF;
    m_err_to = 0;
    m_ovr = 0;
    access(27'h0001234, 1, 1, 0, 8'h00, 2, 0, "post_rst");
    access(27'h0001234, 1, 1, 0, 8'h00, 2, 0, "post_hit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
